// File: rtl/cpu_pkg.sv
// Shared CPU fetch-stage definitions: default PC width and the program-counter
// command priority encoding used by pc_stack_unit.
package cpu_pkg;

    localparam int PC_WIDTH = 8;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_RET    = 3'd3,
        PC_CALL   = 3'd4,
        PC_LOAD   = 3'd5
    } pc_cmd_e;

    // Strongest strobe wins: load > call > ret > branch > inc > hold.
    function automatic pc_cmd_e pc_cmd_encode(
        input logic load,
        input logic call,
        input logic ret,
        input logic branch,
        input logic inc
    );
        pc_cmd_e cmd;
        if (load)        cmd = PC_LOAD;
        else if (call)   cmd = PC_CALL;
        else if (ret)    cmd = PC_RET;
        else if (branch) cmd = PC_BRANCH;
        else if (inc)    cmd = PC_INC;
        else             cmd = PC_HOLD;
        return cmd;
    endfunction

endpackage

// File: rtl/pc_stack_unit_ret_stack.sv
// Return-address LIFO for pc_stack_unit. Push while full and pop while empty
// are silently ignored; the caller decides whether that is an error.
module ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [WIDTH-1:0]                 din,
    output logic [WIDTH-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]       sp,
    output logic                             full,
    output logic                             empty
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]  sp_dec;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign sp_dec  = sp - SP_W'(1);
    assign wr_idx  = sp[IDX_W-1:0];
    assign rd_idx  = sp_dec[IDX_W-1:0];
    assign dout    = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SP_W'(1);
        end else if (do_pop) begin
            sp <= sp_dec;
        end
    end

    // Contents are left untouched by reset; sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with absolute/relative jumps and a hardware
// return-address stack for call/return, plus a sticky stack error flag.
module pc_stack_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         branch,
    input  logic                         inc,
    input  logic [WIDTH-1:0]             target,
    input  logic [WIDTH-1:0]             offset,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         stack_err
);

    pc_cmd_e          cmd;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] stack_top;
    logic             push;
    logic             pop;
    logic             err_set;

    assign cmd      = pc_cmd_encode(load, call, ret, branch, inc);
    assign pc_plus1 = pc + WIDTH'(1);
    assign push     = (cmd == PC_CALL) && !stack_full;
    assign pop      = (cmd == PC_RET) && !stack_empty;
    assign err_set  = ((cmd == PC_CALL) && stack_full) ||
                      ((cmd == PC_RET) && stack_empty);

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_plus1),
        .dout  (stack_top),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // A suppressed call or ret leaves pc where it is.
    always_comb begin
        pc_next = pc;
        case (cmd)
            PC_LOAD:   pc_next = target;
            PC_CALL:   pc_next = stack_full ? pc : target;
            PC_RET:    pc_next = stack_empty ? pc : stack_top;
            PC_BRANCH: pc_next = pc + offset;
            PC_INC:    pc_next = pc_plus1;
            default:   pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stack_err <= 1'b0;
        end else if (err_set) begin
            stack_err <= 1'b1;
        end else if (err_clr) begin
            stack_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios followed by random
// command traffic, all checked against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 4;
    localparam logic [7:0] RESET_VEC = 8'h10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, call, ret, branch, inc, err_clr;
    logic [7:0] target, offset;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       stack_full, stack_empty, stack_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] m_pc;
    logic [7:0] m_stack [$];
    logic       m_err;

    pc_stack_unit #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VEC (RESET_VEC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .call        (call),
        .ret         (ret),
        .branch      (branch),
        .inc         (inc),
        .target      (target),
        .offset      (offset),
        .err_clr     (err_clr),
        .pc          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        assert (obs === expv) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: priority chain of the architectural rules, stack as a queue.
    task automatic modelStep();
        logic set_err;
        set_err = 1'b0;
        if (!rst_n) begin
            m_pc = RESET_VEC;
            m_stack.delete();
            m_err = 1'b0;
        end else begin
            if (load) begin
                m_pc = target;
            end else if (call) begin
                if (m_stack.size() == DEPTH) set_err = 1'b1;
                else begin
                    m_stack.push_back(8'(m_pc + 1));
                    m_pc = target;
                end
            end else if (ret) begin
                if (m_stack.size() == 0) set_err = 1'b1;
                else m_pc = m_stack.pop_back();
            end else if (branch) begin
                m_pc = 8'(m_pc + offset);
            end else if (inc) begin
                m_pc = 8'(m_pc + 1);
            end
            if (set_err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic c, input logic rt,
                                 input logic b, input logic i, input logic [7:0] t,
                                 input logic [7:0] o, input logic ec);
        rst_n = r; load = l; call = c; ret = rt; branch = b; inc = i;
        target = t; offset = o; err_clr = ec;
        @(posedge clk);
        #1;
        modelStep();
        checkOutput("model_pc", 32'(pc), 32'(m_pc));
        checkOutput("model_sp", 32'(sp), 32'(m_stack.size()));
        checkOutput("model_full", 32'(stack_full), 32'(m_stack.size() == DEPTH));
        checkOutput("model_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
        checkOutput("model_err", 32'(stack_err), 32'(m_err));
        rst_n = 1'b1; load = 0; call = 0; ret = 0; branch = 0; inc = 0; err_clr = 0;
    endtask

    initial begin
        rst_n = 1'b0; load = 0; call = 0; ret = 0; branch = 0; inc = 0; err_clr = 0;
        target = '0; offset = '0;
        m_pc = '0; m_err = 1'b0;

        // Reset then increment
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        checkOutput("rst_pc", 32'(pc), 32'h10);
        checkOutput("rst_sp", 32'(sp), 32'h0);
        checkOutput("rst_err", 32'(stack_err), 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        checkOutput("inc3_pc", 32'(pc), 32'h13);
        checkOutput("inc3_empty", 32'(stack_empty), 32'h1);

        // Wrap on inc and signed branches
        applyStimulus(1, 1, 0, 0, 0, 0, 8'hFF, 8'h00, 0);
        checkOutput("load_ff", 32'(pc), 32'hFF);
        applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        checkOutput("inc_wrap", 32'(pc), 32'h00);
        applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 8'hFE, 0);
        checkOutput("branch_neg", 32'(pc), 32'hFE);
        applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 8'h05, 0);
        checkOutput("branch_wrap", 32'(pc), 32'h03);

        // Nested call/ret
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h20, 8'h00, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 8'h80, 8'h00, 0);
        checkOutput("call1_pc", 32'(pc), 32'h80);
        checkOutput("call1_sp", 32'(sp), 32'h1);
        applyStimulus(1, 0, 1, 0, 0, 0, 8'h90, 8'h00, 0);
        checkOutput("call2_pc", 32'(pc), 32'h90);
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0);
        checkOutput("ret1_pc", 32'(pc), 32'h81);
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0);
        checkOutput("ret2_pc", 32'(pc), 32'h21);
        checkOutput("ret2_empty", 32'(stack_empty), 32'h1);

        // Overflow then underflow
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, 1, 0, 0, 0, 8'(8'h40 + k), 8'h00, 0);
        checkOutput("ovf_pc", 32'(pc), 32'h43);
        checkOutput("ovf_sp", 32'(sp), 32'h4);
        checkOutput("ovf_full", 32'(stack_full), 32'h1);
        checkOutput("ovf_err", 32'(stack_err), 32'h1);
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0);
        checkOutput("unw1_pc", 32'(pc), 32'h43);
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0);
        checkOutput("unw4_pc", 32'(pc), 32'h01);
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0);
        checkOutput("udf_pc", 32'(pc), 32'h01);
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
        checkOutput("errclr", 32'(stack_err), 32'h0);

        // Priority: load beats everything, then ret beats inc even when suppressed
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h10, 8'h00, 0);
        applyStimulus(1, 1, 1, 1, 1, 1, 8'h55, 8'h03, 0);
        checkOutput("prio_pc", 32'(pc), 32'h55);
        checkOutput("prio_sp", 32'(sp), 32'h0);
        applyStimulus(1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 0);
        checkOutput("prio_ret_pc", 32'(pc), 32'h55);
        checkOutput("prio_ret_err", 32'(stack_err), 32'h1);

        // Error set wins over simultaneous clear
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1);
        checkOutput("set_wins", 32'(stack_err), 32'h1);

        // Reset mid-sequence
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
        applyStimulus(1, 0, 1, 0, 0, 0, 8'h30, 8'h00, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 8'h38, 8'h00, 0);
        checkOutput("pre_rst_sp", 32'(sp), 32'h2);
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h77, 8'h00, 0);
        checkOutput("mid_rst_pc", 32'(pc), 32'h10);
        checkOutput("mid_rst_sp", 32'(sp), 32'h0);
        checkOutput("mid_rst_err", 32'(stack_err), 32'h0);
        applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0);
        checkOutput("post_rst_err", 32'(stack_err), 32'h1);
        checkOutput("post_rst_pc", 32'(pc), 32'h10);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 59) != 0,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 20,
                          $urandom_range(0, 99) < 40,
                          8'($urandom),
                          8'($urandom),
                          $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter for the CPU fetch stage. Generalises the 8-bit load/increment counter.
- Adds configurable width, a PC-relative branch (signed offset), and a hardware return-address stack of configurable depth for call/return.
- Output `pc` drives the instruction-memory address each cycle. The control decoder drives exactly one intended command per cycle; priority resolves overlaps.

Parameters:
- WIDTH, 8, PC/address width in bits (>=4).
- DEPTH, 4, return-stack entries (>=1).
- RESET_VEC, 0, PC value after reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- load  input  1  absolute jump: pc <= target.
- call  input  1  push pc+1, then pc <= target.
- ret  input  1  pop top of stack into pc.
- branch  input  1  relative jump: pc <= pc + sign-extended offset.
- inc  input  1  pc <= pc + 1.
- target  input  WIDTH  absolute address for load/call.
- offset  input  WIDTH  two's-complement branch offset.
- err_clr  input  1  clears sticky stack_err.
- pc  output  WIDTH  current program counter (registered).
- sp  output  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH.
- stack_full  output  1  sp == DEPTH (combinational from sp).
- stack_empty  output  1  sp == 0 (combinational from sp).
- stack_err  output  1  sticky: overflow or underflow attempted.

Behaviour:
- Reset (rst_n low at a rising edge), overriding everything:
  - pc=RESET_VEC, sp=0, stack_err=0.
  - Stack contents are don't-care and need not be cleared.
  - Reset mid-sequence discards all pending return addresses.
- Command priority, one action per cycle: load > call > ret > branch > inc > hold. Lower-priority commands asserted in the same cycle are ignored, with no side effects.
- load: pc <= target; sp unchanged.
- call, not full:
  - stack[sp] <= pc+1 mod 2^WIDTH; sp <= sp+1; pc <= target.
- call when full:
  - Entire operation suppressed: pc, sp and stack unchanged.
  - stack_err <= 1.
- ret, not empty: pc <= stack[sp-1]; sp <= sp-1.
- ret when empty:
  - Suppressed: pc unchanged.
  - stack_err <= 1.
- branch: pc <= pc + offset, modulo 2^WIDTH (signed add, wrap silently, no flag).
- inc: pc <= pc+1 mod 2^WIDTH; max value wraps to 0.
- Latency: every command updates pc at the same edge it is sampled; new pc is visible the following cycle.
- Back-to-back call/ret is supported every cycle with no bubbles.
- Call immediately followed by ret returns to the caller's pc+1.
- stack_err:
  - Sets on a suppressed call or ret.
  - Clears on err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.
  - Setting stack_err does not block further commands.
- stack_full and stack_empty reflect the registered sp and are never both 1 (DEPTH>=1).
- No X propagation: with no command asserted, all state holds.

Decomposition:
- Shared package cpu_pkg:
  - PC_WIDTH default constant.
  - Command-priority enum pc_cmd_e: PC_HOLD, PC_INC, PC_BRANCH, PC_RET, PC_CALL, PC_LOAD.
  - Priority-encode function from the five strobes to pc_cmd_e, reused by the decoder's assertions.
- One sub-module, ret_stack: LIFO, WIDTH x DEPTH.
  - Inputs: push, pop, din. Outputs: dout (top), sp, full, empty.
  - Push when full and pop when empty are ignored internally.
  - Top-level owns pc, priority and stack_err.

Test Plan:
1. Reset and increment, WIDTH=8, RESET_VEC=8'h10: hold rst_n low 2 cycles, then inc for 3 cycles -> pc 0x10, 0x11, 0x12, 0x13; sp=0, stack_empty=1.
2. Wrap, WIDTH=8: load target=0xFF, then inc -> pc 0xFF then 0x00. Then branch offset=0xFE (-2) -> pc 0xFE. Then branch offset=0x05 -> pc 0x03.
3. Nested call/ret:
   - At pc=0x20, call target=0x80 -> pc=0x80, sp=1.
   - call target=0x90 -> pc=0x90, sp=2.
   - ret -> pc=0x81, sp=1.
   - ret -> pc=0x21, sp=0, stack_empty=1.
4. Overflow/underflow, DEPTH=4:
   - Five calls (targets 0x40..0x44) from pc=0x00 -> fifth suppressed; pc stays 0x43, sp=4, stack_full=1, stack_err=1.
   - Four rets -> pc 0x43 (from the call at 0x42), then 0x42, 0x41, 0x01; a fifth ret -> pc holds 0x01.
   - err_clr -> stack_err=0.
5. Priority: in one cycle assert load(target=0x55)+call+ret+branch+inc at pc=0x10 -> pc=0x55, sp unchanged. Next cycle ret+inc with sp=0 -> pc=0x55, stack_err=1.
6. Reset mid-operation: after two calls (sp=2), pull rst_n low for one cycle together with call asserted -> pc=RESET_VEC, sp=0, stack_err=0. Next ret -> stack_err=1, pc unchanged.
